// File: rtl/snn_pkg.sv
// Shared types and defaults for the SNN mode sequencer and its readout pipe.
package snn_pkg;

  localparam int IMG_WORDS_DEFAULT  = 25;
  localparam int INIT_WORDS_DEFAULT = 1024;
  localparam int N_NEURON_DEFAULT   = 10;

  localparam logic [1:0] MODE_INFER = 2'd0;
  localparam logic [1:0] MODE_STO   = 2'd1;
  localparam logic [1:0] MODE_TRAIN = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_IMG,
    S_LABEL,
    S_START,
    S_RUN,
    S_READ,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/snn_readout_pipe.sv
// Neuron-voltage readout: issues read addresses and returns each voltage one
// cycle later as an output beat, holding any in-flight beat across pause.
module snn_readout_pipe
  import snn_pkg::*;
#(
  parameter int N_NEURON = N_NEURON_DEFAULT,
  parameter int NA_W     = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            active,
  input  logic            pause,
  input  logic [13:0]     core_rd_data,
  output logic [NA_W-1:0] core_rd_addr,
  output logic            output_valid,
  output logic [13:0]     neuron_voltages,
  output logic            last_beat
);

  localparam int            IW      = NA_W + 1;
  localparam logic [IW-1:0] IDX_END = IW'(N_NEURON);

  logic [IW-1:0] idx;
  logic [IW-1:0] idx_prev;
  logic          pend;
  logic [13:0]   hold_q;
  logic          issue;
  logic          consume;

  // While a beat is pending but nothing new issues, keep its address on the
  // bus so the core keeps returning the same word until it is consumed.
  always_comb begin
    issue           = active && !pause && (idx < IDX_END);
    consume         = pend && !pause;
    idx_prev        = idx - IW'(1);
    core_rd_addr    = (pend && !issue) ? idx_prev[NA_W-1:0] : idx[NA_W-1:0];
    output_valid    = consume;
    neuron_voltages = consume ? core_rd_data : hold_q;
    last_beat       = consume && (idx == IDX_END);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx    <= '0;
      pend   <= 1'b0;
      hold_q <= '0;
    end else begin
      if (!active) begin
        idx  <= '0;
        pend <= 1'b0;
      end else begin
        if (issue) begin
          idx <= idx + IW'(1);
        end
        if (issue) begin
          pend <= 1'b1;
        end else if (consume) begin
          pend <= 1'b0;
        end
      end
      if (consume) begin
        hold_q <= core_rd_data;
      end
    end
  end

endmodule

// File: rtl/snn_mode_sequencer.sv
// Central controller between the pad ring and the SNN core: decodes mode
// commands and sequences init streaming, image/label fetch, run and readout.
module snn_mode_sequencer
  import snn_pkg::*;
#(
  parameter int IMG_WORDS  = IMG_WORDS_DEFAULT,
  parameter int INIT_WORDS = INIT_WORDS_DEFAULT,
  parameter int N_NEURON   = N_NEURON_DEFAULT,
  parameter int IA_W       = 10,
  parameter int MA_W       = 5,
  parameter int NA_W       = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            initialize,
  input  logic            train,
  input  logic            infer,
  input  logic            sto_infer,
  input  logic            pause,
  input  logic            input_valid,
  input  logic [31:0]     image,
  input  logic [13:0]     init_val,
  input  logic [3:0]      label0,
  output logic            img_request,
  output logic            label_request,
  output logic            init_fin,
  output logic            output_valid,
  output logic [13:0]     neuron_voltages,
  output logic            core_init_we,
  output logic [IA_W-1:0] core_init_addr,
  output logic [13:0]     core_init_data,
  output logic            core_img_we,
  output logic [MA_W-1:0] core_img_addr,
  output logic [31:0]     core_img_data,
  output logic [3:0]      core_label,
  output logic [1:0]      core_mode,
  output logic            core_start,
  input  logic            core_done,
  output logic [NA_W-1:0] core_rd_addr,
  input  logic [13:0]     core_rd_data
);

  localparam logic [IA_W-1:0] INIT_LAST = IA_W'(INIT_WORDS - 1);
  localparam logic [MA_W-1:0] IMG_LAST  = MA_W'(IMG_WORDS - 1);

  seq_state_t      state;
  seq_state_t      state_nx;
  logic [IA_W-1:0] init_cnt;
  logic [MA_W-1:0] img_cnt;
  logic            done_seen;
  logic            cmd_any;
  logic            cmd_take;
  logic [1:0]      cmd_mode;
  logic            init_wr;
  logic            img_wr;
  logic            label_take;
  logic            run_exit;
  logic            read_last;

  always_comb begin
    cmd_any        = initialize || train || sto_infer || infer;
    cmd_take       = (state == S_IDLE) && !pause && cmd_any;
    cmd_mode       = train ? MODE_TRAIN : (sto_infer ? MODE_STO : MODE_INFER);
    init_wr        = (state == S_INIT) && !pause && input_valid;
    img_request    = (state == S_IMG) && !pause;
    img_wr         = img_request && input_valid;
    label_request  = (state == S_LABEL) && !pause;
    label_take     = label_request && input_valid;
    core_start     = (state == S_START) && !pause;
    run_exit       = (state == S_RUN) && !pause && (done_seen || core_done);
    core_init_we   = init_wr;
    core_init_addr = init_cnt;
    core_init_data = init_wr ? init_val : '0;
    core_img_we    = img_wr;
    core_img_addr  = img_cnt;
    core_img_data  = img_wr ? image : '0;

    state_nx = state;
    if (!pause) begin
      case (state)
        S_IDLE:  if (initialize) state_nx = S_INIT;
                 else if (cmd_any) state_nx = S_IMG;
        S_INIT:  if (init_wr && (init_cnt == INIT_LAST)) state_nx = S_IDLE;
        S_IMG:   if (img_wr && (img_cnt == IMG_LAST))
                   state_nx = (core_mode == MODE_TRAIN) ? S_LABEL : S_START;
        S_LABEL: if (label_take) state_nx = S_START;
        S_START: state_nx = S_RUN;
        S_RUN:   if (run_exit) state_nx = S_READ;
        S_READ:  if (read_last) state_nx = S_DONE;
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Counters return to zero on their terminal write, so they never wrap and
  // the address buses sit at zero between transfers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      init_cnt   <= '0;
      img_cnt    <= '0;
      init_fin   <= 1'b0;
      core_mode  <= MODE_INFER;
      core_label <= '0;
      done_seen  <= 1'b0;
    end else begin
      if (cmd_take) begin
        init_cnt <= '0;
        img_cnt  <= '0;
        if (initialize) begin
          init_fin <= 1'b0;
        end else begin
          core_mode <= cmd_mode;
        end
      end
      if (init_wr) begin
        if (init_cnt == INIT_LAST) begin
          init_cnt <= '0;
          init_fin <= 1'b1;
        end else begin
          init_cnt <= init_cnt + IA_W'(1);
        end
      end
      if (img_wr) begin
        img_cnt <= (img_cnt == IMG_LAST) ? '0 : img_cnt + MA_W'(1);
      end
      if (label_take) begin
        core_label <= label0;
      end
      done_seen <= (state == S_RUN) && !run_exit && (done_seen || core_done);
    end
  end

  snn_readout_pipe #(
    .N_NEURON (N_NEURON),
    .NA_W     (NA_W)
  ) u_readout (
    .clk             (clk),
    .resetn          (resetn),
    .active          (state == S_READ),
    .pause           (pause),
    .core_rd_data    (core_rd_data),
    .core_rd_addr    (core_rd_addr),
    .output_valid    (output_valid),
    .neuron_voltages (neuron_voltages),
    .last_beat       (read_last)
  );

endmodule

// File: tb/tb_snn_mode_sequencer.sv
// Directed bench for snn_mode_sequencer: scoreboards of expected core writes
// and readout beats are checked every cycle, plus literal spot checks.
module tb_snn_mode_sequencer;

  localparam int IMG_WORDS  = 25;
  localparam int INIT_WORDS = 1024;
  localparam int N_NEURON   = 10;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        initialize = 1'b0, train = 1'b0, infer = 1'b0, sto_infer = 1'b0;
  logic        pause = 1'b0, input_valid = 1'b0;
  logic [31:0] image = '0;
  logic [13:0] init_val = '0;
  logic [3:0]  label0 = '0;
  logic        core_done = 1'b0;
  logic [13:0] core_rd_data = '0;

  logic        img_request, label_request, init_fin, output_valid;
  logic [13:0] neuron_voltages;
  logic        core_init_we;
  logic [9:0]  core_init_addr;
  logic [13:0] core_init_data;
  logic        core_img_we;
  logic [4:0]  core_img_addr;
  logic [31:0] core_img_data;
  logic [3:0]  core_label;
  logic [1:0]  core_mode;
  logic        core_start;
  logic [3:0]  core_rd_addr;

  int          checks = 0;
  int          errors = 0;
  int          start_count = 0;
  wr_t         exp_init_q[$];
  wr_t         exp_img_q[$];
  int          exp_beat_q[$];
  int          last_v = 0;
  wr_t         cmp_w;
  int          cmp_v;

  always #5 clk = ~clk;

  snn_mode_sequencer dut (
    .clk             (clk),
    .resetn          (resetn),
    .initialize      (initialize),
    .train           (train),
    .infer           (infer),
    .sto_infer       (sto_infer),
    .pause           (pause),
    .input_valid     (input_valid),
    .image           (image),
    .init_val        (init_val),
    .label0          (label0),
    .img_request     (img_request),
    .label_request   (label_request),
    .init_fin        (init_fin),
    .output_valid    (output_valid),
    .neuron_voltages (neuron_voltages),
    .core_init_we    (core_init_we),
    .core_init_addr  (core_init_addr),
    .core_init_data  (core_init_data),
    .core_img_we     (core_img_we),
    .core_img_addr   (core_img_addr),
    .core_img_data   (core_img_data),
    .core_label      (core_label),
    .core_mode       (core_mode),
    .core_start      (core_start),
    .core_done       (core_done),
    .core_rd_addr    (core_rd_addr),
    .core_rd_data    (core_rd_data)
  );

  // Synchronous voltage memory of the core: voltage = 100 + address.
  always @(posedge clk) core_rd_data <= 14'(100 + int'(core_rd_addr));

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every cycle: writes and beats must match the scoreboards in order, pause
  // must silence all strobes, and idle voltages must hold the last beat.
  always @(negedge clk) begin
    if (!resetn) begin
      last_v = 0;
    end else begin
      if (pause)
        check_output("pause_strobes", {img_request, label_request, output_valid,
                                       core_init_we, core_img_we, core_start}, 0);
      if (core_init_we) begin
        if (exp_init_q.size() == 0) check_output("init_we_unexpected", 1, 0);
        else begin
          cmp_w = exp_init_q.pop_front();
          check_output("init_addr", core_init_addr, cmp_w.addr);
          check_output("init_data", core_init_data, cmp_w.data);
        end
      end
      if (core_img_we) begin
        if (exp_img_q.size() == 0) check_output("img_we_unexpected", 1, 0);
        else begin
          cmp_w = exp_img_q.pop_front();
          check_output("img_addr", core_img_addr, cmp_w.addr);
          check_output("img_data", core_img_data, cmp_w.data);
        end
      end
      if (output_valid) begin
        if (exp_beat_q.size() == 0) check_output("beat_unexpected", 1, 0);
        else begin
          cmp_v = exp_beat_q.pop_front();
          check_output("beat_value", neuron_voltages, cmp_v);
          last_v = cmp_v;
        end
      end else begin
        check_output("voltage_hold", neuron_voltages, last_v);
      end
      if (core_start) start_count++;
    end
  end

  task automatic apply_reset();
    resetn = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_output("rst_flags", {img_request, label_request, init_fin, output_valid,
                               core_init_we, core_img_we, core_start}, 0);
    check_output("rst_voltages", neuron_voltages, 0);
    check_output("rst_addrs", {core_init_addr, core_img_addr, core_rd_addr}, 0);
    check_output("rst_data", {core_init_data, core_img_data}, 0);
    check_output("rst_label_mode", {core_label, core_mode}, 0);
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic stream_init(input bit invert);
    wr_t w;
    for (int i = 0; i < INIT_WORDS; i++) begin
      w.addr = i;
      w.data = invert ? 32'(16383 - i) : 32'(i);
      exp_init_q.push_back(w);
    end
    for (int i = 0; i < INIT_WORDS; i++) begin
      input_valid = 1'b1;
      init_val    = invert ? 14'(16383 - i) : 14'(i);
      if (i == INIT_WORDS - 1) begin
        @(negedge clk);
        check_output("init_fin_low_at_last", init_fin, 0);
        check_output("init_last_addr", core_init_addr, 1023);
      end
      tick();
    end
    input_valid = 1'b0;
    @(negedge clk);
    check_output("init_fin_rise", init_fin, 1);
    tick();
  endtask

  task automatic feed_image(input logic [31:0] base, input int pause_at);
    wr_t w;
    for (int k = 0; k < IMG_WORDS; k++) begin
      w.addr = k;
      w.data = base + 32'(k);
      exp_img_q.push_back(w);
    end
    for (int k = 0; k < IMG_WORDS; k++) begin
      input_valid = 1'b1;
      image       = base + 32'(k);
      if (k == pause_at) begin
        pause = 1'b1;
        repeat (5) tick();
        pause = 1'b0;
      end
      if (k == 0) begin
        @(negedge clk);
        check_output("img_word0", {27'(core_img_addr), core_img_data[4:0]}, {27'd0, base[4:0]});
        tick();
      end else if (k == IMG_WORDS - 1) begin
        @(negedge clk);
        check_output("no_label_req_before_last", label_request, 0);
        tick();
      end else begin
        tick();
      end
    end
    input_valid = 1'b0;
  endtask

  task automatic run_core(input bit pause_at_done, input int pause_beat);
    int waited;
    int seen;
    int starts_before;
    bit pb_done;
    starts_before = start_count;
    for (int b = 0; b < N_NEURON; b++) exp_beat_q.push_back(100 + b);
    waited = 0;
    @(negedge clk);
    while (!core_start && waited < 20) begin
      tick();
      @(negedge clk);
      waited++;
    end
    check_output("core_start_seen", core_start, 1);
    repeat (20) tick();
    core_done = 1'b1;
    if (pause_at_done) pause = 1'b1;
    tick();
    core_done = 1'b0;
    if (pause_at_done) begin
      repeat (3) tick();
      pause = 1'b0;
    end
    seen = 0;
    waited = 0;
    pb_done = 1'b0;
    while (seen < N_NEURON && waited < 80) begin
      @(negedge clk);
      if (output_valid) seen++;
      waited++;
      if (!pb_done && pause_beat > 0 && seen == pause_beat) begin
        pb_done = 1'b1;
        tick();
        pause = 1'b1;
        repeat (3) tick();
        pause = 1'b0;
      end else begin
        tick();
      end
    end
    check_output("beat_count", seen, N_NEURON);
    @(negedge clk);
    check_output("no_extra_beat", output_valid, 0);
    check_output("hold_last_beat_109", neuron_voltages, 109);
    check_output("single_start", start_count - starts_before, 1);
    check_output("beat_queue_drained", exp_beat_q.size(), 0);
    tick();
  endtask

  initial begin
    apply_reset();

    $display("[TB] init stream");
    initialize = 1'b1;
    tick();
    initialize = 1'b0;
    stream_init(1'b0);
    repeat (3) tick();
    @(negedge clk);
    check_output("init_fin_holds", init_fin, 1);
    check_output("init_queue_drained", exp_init_q.size(), 0);
    tick();

    $display("[TB] infer");
    infer = 1'b1;
    tick();
    infer = 1'b0;
    @(negedge clk);
    check_output("infer_mode", core_mode, 0);
    check_output("infer_img_req", img_request, 1);
    tick();
    feed_image(32'hA5A5_0000, -1);
    run_core(1'b0, -1);

    $display("[TB] train");
    train = 1'b1;
    tick();
    train = 1'b0;
    @(negedge clk);
    check_output("train_mode", core_mode, 2);
    tick();
    feed_image(32'h1234_0000, -1);
    @(negedge clk);
    check_output("label_req_after_last", label_request, 1);
    check_output("img_req_off_in_label", img_request, 0);
    tick();
    label0      = 4'd7;
    input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
    label0      = 4'd0;
    run_core(1'b0, -1);
    check_output("train_label", core_label, 7);

    $display("[TB] priority");
    initialize = 1'b1;
    train      = 1'b1;
    infer      = 1'b1;
    tick();
    initialize = 1'b0;
    train      = 1'b0;
    infer      = 1'b0;
    @(negedge clk);
    check_output("prio_no_img_req", img_request, 0);
    check_output("prio_init_fin_cleared", init_fin, 0);
    check_output("prio_mode_untouched", core_mode, 2);
    tick();
    image  = 32'hDEAD_BEEF;
    label0 = 4'd3;
    stream_init(1'b1);
    @(negedge clk);
    check_output("prio_label_untouched", core_label, 7);
    tick();

    $display("[TB] pause");
    sto_infer = 1'b1;
    tick();
    sto_infer = 1'b0;
    @(negedge clk);
    check_output("sto_mode", core_mode, 1);
    tick();
    feed_image(32'h0F0F_0000, 12);
    run_core(1'b1, 4);
    check_output("img_queue_drained", exp_img_q.size(), 0);

    $display("[TB] reset mid-run");
    train = 1'b1;
    tick();
    train = 1'b0;
    tick();
    feed_image(32'h5555_0000, -1);
    label0      = 4'd5;
    input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    check_output("pre_reset_state", {init_fin, core_label, core_mode}, {1'b1, 4'd5, 2'd2});
    tick();
    #2;
    resetn = 1'b0;
    #1;
    check_output("async_rst_regs", {init_fin, core_label, core_mode}, 0);
    check_output("async_rst_strobes", {img_request, label_request, output_valid, core_start}, 0);
    tick();
    resetn = 1'b1;
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    repeat (15) tick();
    @(negedge clk);
    check_output("late_done_ignored", {output_valid, img_request}, 0);
    tick();
    infer = 1'b1;
    tick();
    infer = 1'b0;
    @(negedge clk);
    check_output("idle_after_reset", img_request, 1);
    check_output("final_img_queue", exp_img_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snn_mode_sequencer.md
Name: snn_mode_sequencer

Overview:
- Central controller between the pad ring and the SNN core (`top`).
- Decodes the pad-level mode commands: initialize, train, infer, sto_infer.
- Sequences each mode's phases:
  - weight-init streaming;
  - image-word fetch, using the img_request/input_valid handshake;
  - label fetch (train only);
  - core run;
  - serialized neuron-voltage readout on the 14-bit output bus.
- pause freezes the sequencer at any phase without losing state.

Parameters:
- IMG_WORDS, 25: 32-bit image words per sample (784 pixels, last word padded).
- INIT_WORDS, 1024: 14-bit init values streamed in INIT.
- N_NEURON, 10: output neurons read out per sample.
- IA_W, 10: init address width; must satisfy 2^IA_W >= INIT_WORDS.
- MA_W, 5: image address width; must satisfy 2^MA_W >= IMG_WORDS.
- NA_W, 4: neuron address width; must satisfy 2^NA_W >= N_NEURON.

Ports:
- clk  in  1  core clock
- resetn  in  1  reset; asynchronous, active-low
- initialize  in  1  command: stream init values
- train  in  1  command: load image + label, run in train mode
- infer  in  1  command: deterministic inference
- sto_infer  in  1  command: stochastic inference
- pause  in  1  freeze sequencer
- input_valid  in  1  host data-valid strobe
- image  in  32  image word
- init_val  in  14  init value
- label0  in  4  class label
- img_request  out  1  requesting an image word
- label_request  out  1  requesting a label
- init_fin  out  1  init stream complete
- output_valid  out  1  neuron_voltages valid
- neuron_voltages  out  14  one neuron voltage per valid beat
- core_init_we / core_init_addr / core_init_data  out  1/IA_W/14  init write port
- core_img_we / core_img_addr / core_img_data  out  1/MA_W/32  image write port
- core_label  out  4  latched label
- core_mode  out  2  0=infer, 1=sto_infer, 2=train
- core_start  out  1  one-cycle run pulse
- core_done  in  1  one-cycle run-complete pulse
- core_rd_addr  out  NA_W  voltage read address
- core_rd_data  in  14  voltage, valid one cycle after core_rd_addr

Behaviour:

Reset:
- resetn low clears everything immediately, including mid-operation.
- State goes to IDLE; all counters and all outputs reset to 0, including core_label and core_mode.

States: IDLE, INIT, IMG, LABEL, START, RUN, READ, DONE.

IDLE:
- Commands are sampled only in IDLE while pause=0.
- Priority when several are high: initialize > train > sto_infer > infer.
- initialize goes to INIT and clears init_fin.
- Any other command sets core_mode and goes to IMG.
- Commands are ignored in every other state.

INIT:
- Each cycle with input_valid=1 and pause=0 pulses core_init_we, with core_init_addr = counter and core_init_data = init_val; the counter then increments.
- After write INIT_WORDS-1 the next state is IDLE and init_fin is set.
- init_fin stays high until the next initialize command.

IMG:
- img_request=1 while the state is IMG and pause=0.
- A word is accepted when img_request=1 and input_valid=1, same cycle (zero-latency accept). On accept, core_img_we pulses with address = counter and data = image.
- After word IMG_WORDS-1: train goes to LABEL; infer/sto_infer go to START.

LABEL:
- label_request=1 while pause=0.
- On input_valid, latch label0 into core_label (the value is passed unchecked) and go to START.

START:
- Pulse core_start for exactly one cycle, then go to RUN.

RUN:
- Wait for core_done; then go to READ with the read index at 0.
- core_done is captured in a sticky flag, so a pulse arriving while paused is not lost.
- A core_done seen outside RUN is ignored.

READ:
- Drive core_rd_addr = index, then index+1.
- One cycle later, drive output_valid=1 and neuron_voltages = core_rd_data.
- This gives N_NEURON back-to-back beats when unpaused. After the last beat, go to DONE.

DONE:
- One cycle, then IDLE.
- A command held high starts the next sample on the following cycle.

pause:
- All state and counters hold.
- img_request, label_request, output_valid, core_*_we and core_start are forced to 0.
- The read pipeline holds. A beat in flight is re-presented after resume, never dropped or duplicated.

Other rules:
- input_valid outside INIT/IMG/LABEL is ignored.
- neuron_voltages holds its last value when output_valid=0.
- Counters never wrap: the terminal compare forces the state exit.

Decomposition:
- Shared package snn_pkg holds:
  - the state enum;
  - the core_mode encodings MODE_INFER=0, MODE_STO=1, MODE_TRAIN=2;
  - the IMG_WORDS, INIT_WORDS and N_NEURON defaults.
- One sub-module, snn_readout_pipe: the read-index counter plus the one-cycle data-return register with pause hold, producing output_valid and neuron_voltages.

Test Plan:
- Init stream:
  - Stimulus: initialize=1 for one cycle, then 1024 input_valid beats with init_val = index.
  - Required: 1024 core_init_we pulses at addresses 0..1023; init_fin rises the cycle after the last write and holds.
- Infer:
  - Stimulus: infer=1, 25 words with image = 0xA5A50000+k; core_done 20 cycles after core_start; core_rd_data = 100+addr.
  - Required: core_mode=0; one core_start; 10 consecutive output_valid beats carrying 100..109; return to IDLE.
- Train:
  - Stimulus: train=1, 25 words, then label0=7.
  - Required: label_request only after the 25th word; core_label=7; core_mode=2; core_start once.
- Priority:
  - Stimulus: initialize, train and infer all high in IDLE.
  - Required: INIT entered; image/label path untouched.
- Pause:
  - Stimulus: pause at image word 12 for 5 cycles while input_valid stays high; pause again during readout beat 4.
  - Required: no writes while paused; words 12..24 written exactly once; beats 0..9 each seen exactly once, in order.
- Reset mid-run:
  - Stimulus: resetn low during RUN.
  - Required: all outputs 0 asynchronously; IDLE after release; a late core_done is ignored.
